// File: rtl/wshb_arb_pkg.sv
// rtl/wshb_arb_pkg.sv - shared state type and defaults for the two-master Wishbone arbiter
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_QUANTUM = 64;
  localparam int ADR_W           = 32;

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone B4 classic bus bundle with master and slave views
interface wshb_if #(
  parameter int DATA_BYTES = 4
) ();
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [31:0]             adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_arb_pick.sv
// rtl/wshb_arb_pick.sv - combinational round-robin next-grant selector for two masters
import wshb_arb_pkg::*;

module wshb_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  arb_state_t state,
  output arb_state_t next_state
);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        // On a tie the master that was not served most recently wins.
        if (req == 2'b11)  next_state = last ? GNT0 : GNT1;
        else if (req[0])   next_state = GNT0;
        else if (req[1])   next_state = GNT1;
        else               next_state = IDLE;
      end
      GNT0: begin
        if (!req[0]) next_state = req[1] ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!req[1]) next_state = req[0] ? GNT0 : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/wshb_arbiter2.sv
// rtl/wshb_arbiter2.sv - two-master round-robin Wishbone arbiter; WSHB_ARB_QUANTUM_EN enables quantum preemption
import wshb_arb_pkg::*;

module wshb_arbiter2 #(
  parameter int DATA_BYTES = 4,
  parameter int QUANTUM    = DEFAULT_QUANTUM
) (
  input  logic   sys_clk,
  input  logic   sys_rst_n,
  wshb_if.slave  wshb_ifs_0,
  wshb_if.slave  wshb_ifs_1,
  wshb_if.master wshb_ifm,
  output logic [1:0] gnt
);

  arb_state_t state;
  arb_state_t state_nxt;
  arb_state_t pick_state;
  logic       last;
  logic [1:0] req;

  assign req = {wshb_ifs_1.cyc, wshb_ifs_0.cyc};

  wshb_arb_pick u_pick (
    .req        (req),
    .last       (last),
    .state      (state),
    .next_state (pick_state)
  );

`ifdef WSHB_ARB_QUANTUM_EN
  localparam int              CNT_W    = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  logic [CNT_W-1:0] qcnt;
  logic [CNT_W-1:0] qcnt_nxt;
  logic             resp;
  logic             preempt;

  assign resp = (state != IDLE) & (wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty);

  // The counter saturates at QUANTUM-1 so a late request from the other
  // master is still honoured on the very next completed transfer.
  always_comb begin
    preempt = 1'b0;
    if (resp && qcnt == CNT_LAST) begin
      if (state == GNT0 && req[1]) preempt = 1'b1;
      if (state == GNT1 && req[0]) preempt = 1'b1;
    end
    state_nxt = pick_state;
    if (preempt) state_nxt = (state == GNT0) ? GNT1 : GNT0;
    qcnt_nxt = qcnt;
    if (state_nxt != state || state_nxt == IDLE) qcnt_nxt = '0;
    else if (resp && qcnt != CNT_LAST)          qcnt_nxt = qcnt + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) qcnt <= '0;
    else            qcnt <= qcnt_nxt;
  end
`else
  logic unused_quantum;
  assign unused_quantum = ^QUANTUM;
  assign state_nxt      = pick_state;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT0) last <= 1'b0;
      if (state_nxt == GNT1) last <= 1'b1;
    end
  end

  assign gnt = {state == GNT1, state == GNT0};

  // Request path is a pure function of the registered state, so an async
  // reset drops the forwarded cyc/stb immediately.
  always_comb begin
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.adr    = '0;
    wshb_ifm.dat_ms = {(8*DATA_BYTES){1'b0}};
    wshb_ifm.sel    = '0;
    wshb_ifm.cti    = '0;
    wshb_ifm.bte    = '0;
    case (state)
      GNT0: begin
        wshb_ifm.cyc    = wshb_ifs_0.cyc;
        wshb_ifm.stb    = wshb_ifs_0.stb;
        wshb_ifm.we     = wshb_ifs_0.we;
        wshb_ifm.adr    = wshb_ifs_0.adr;
        wshb_ifm.dat_ms = wshb_ifs_0.dat_ms;
        wshb_ifm.sel    = wshb_ifs_0.sel;
        wshb_ifm.cti    = wshb_ifs_0.cti;
        wshb_ifm.bte    = wshb_ifs_0.bte;
      end
      GNT1: begin
        wshb_ifm.cyc    = wshb_ifs_1.cyc;
        wshb_ifm.stb    = wshb_ifs_1.stb;
        wshb_ifm.we     = wshb_ifs_1.we;
        wshb_ifm.adr    = wshb_ifs_1.adr;
        wshb_ifm.dat_ms = wshb_ifs_1.dat_ms;
        wshb_ifm.sel    = wshb_ifs_1.sel;
        wshb_ifm.cti    = wshb_ifs_1.cti;
        wshb_ifm.bte    = wshb_ifs_1.bte;
      end
      default: ;
    endcase
  end

  assign wshb_ifs_0.ack    = (state == GNT0) & wshb_ifm.ack;
  assign wshb_ifs_0.err    = (state == GNT0) & wshb_ifm.err;
  assign wshb_ifs_0.rty    = (state == GNT0) & wshb_ifm.rty;
  assign wshb_ifs_1.ack    = (state == GNT1) & wshb_ifm.ack;
  assign wshb_ifs_1.err    = (state == GNT1) & wshb_ifm.err;
  assign wshb_ifs_1.rty    = (state == GNT1) & wshb_ifm.rty;
  assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter2.sv
// tb/tb_wshb_arbiter2.sv - randomized self-checking bench for wshb_arbiter2 against a grant/ownership model
`timescale 1ns/1ps
module tb_wshb_arbiter2;

  localparam int QN = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] gnt;
  always #5 clk = ~clk;

  wshb_if #(.DATA_BYTES(4)) m0 ();
  wshb_if #(.DATA_BYTES(4)) m1 ();
  wshb_if #(.DATA_BYTES(4)) s ();

  logic        cyc_d [2];
  logic        stb_d [2];
  logic        we_d  [2];
  logic [31:0] adr_d [2];
  logic [31:0] dat_d [2];
  logic [3:0]  sel_d [2];
  logic        mack  [2];
  logic [31:0] mdat  [2];

  assign m0.cyc = cyc_d[0];  assign m1.cyc = cyc_d[1];
  assign m0.stb = stb_d[0];  assign m1.stb = stb_d[1];
  assign m0.we  = we_d[0];   assign m1.we  = we_d[1];
  assign m0.adr = adr_d[0];  assign m1.adr = adr_d[1];
  assign m0.dat_ms = dat_d[0]; assign m1.dat_ms = dat_d[1];
  assign m0.sel = sel_d[0];  assign m1.sel = sel_d[1];
  assign m0.cti = 3'b000;    assign m1.cti = 3'b000;
  assign m0.bte = 2'b00;     assign m1.bte = 2'b00;
  assign mack[0] = m0.ack | m0.err | m0.rty;
  assign mack[1] = m1.ack | m1.err | m1.rty;
  assign mdat[0] = m0.dat_sm;
  assign mdat[1] = m1.dat_sm;

  // Behavioural SDRAM slave: combinational ack gated by a random ready.
  logic        ready;
  int          rmode;
  logic [31:0] smem [8];
  assign s.ack    = s.cyc & s.stb & ready;
  assign s.err    = 1'b0;
  assign s.rty    = 1'b0;
  assign s.dat_sm = smem[s.adr[4:2]];
  always @(posedge clk)
    if (s.ack && s.we)
      for (int b = 0; b < 4; b++)
        if (s.sel[b]) smem[s.adr[4:2]][8*b +: 8] <= s.dat_ms[8*b +: 8];

  wshb_arbiter2 #(.DATA_BYTES(4), .QUANTUM(QN)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .wshb_ifs_0 (m0),
    .wshb_ifs_1 (m1),
    .wshb_ifm   (s),
    .gnt        (gnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] ref_mem [8];
  int ack_by [2];
  int done [2];
  int cycles = 0;
  int gseq [$];
  int idle_wait, first_acks;

  initial forever begin
    @(posedge clk);
    cycles++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Ownership model: who owns the slave, who was served last, acks this tenure.
  initial begin
    int owner, mlast, qcnt, nx, o;
    logic [1:0] req, eg, gprev;
    logic ackd;
    owner = -1; mlast = 1; qcnt = 0; gprev = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        owner = -1; mlast = 1; qcnt = 0;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_cyc", {31'd0, s.cyc}, 32'd0);
        chk("rst_ack", {30'd0, mack[1], mack[0]}, 32'd0);
      end else begin
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        if (owner < 0) begin
          chk("idle_fwd", {30'd0, s.cyc, s.stb}, 32'd0);
          chk("idle_ack", {30'd0, mack[1], mack[0]}, 32'd0);
        end else begin
          chk("fwd_cyc", {31'd0, s.cyc}, {31'd0, cyc_d[owner]});
          chk("other_ack", {31'd0, mack[1-owner]}, 32'd0);
          if (s.ack) begin
            chk("fwd_adr", s.adr, adr_d[owner]);
            chk("fwd_we", {31'd0, s.we}, {31'd0, we_d[owner]});
            chk("fwd_sel", {28'd0, s.sel}, {28'd0, sel_d[owner]});
            if (we_d[owner]) chk("fwd_dat", s.dat_ms, dat_d[owner]);
            chk("own_ack", {31'd0, mack[owner]}, 32'd1);
            ack_by[owner]++;
            if (gseq.size() == 1) first_acks++;
          end
        end
        if (gnt != gprev && gnt != 2'b00) gseq.push_back(gnt == 2'b01 ? 0 : 1);
        if (gnt == 2'b00 && (m0.cyc || m1.cyc)) idle_wait++;
        req  = {m1.cyc, m0.cyc};
        ackd = s.ack | s.err | s.rty;
        nx = owner;
        if (owner < 0) begin
          if (req == 2'b11)  nx = (mlast == 1) ? 0 : 1;
          else if (req[0])   nx = 0;
          else if (req[1])   nx = 1;
        end else begin
          o = 1 - owner;
          if (ackd) qcnt++;
          if (!req[owner]) nx = req[o] ? o : -1;
`ifdef WSHB_ARB_QUANTUM_EN
          if (ackd && qcnt >= QN && req[o]) nx = o;
`endif
        end
        if (nx != owner) qcnt = 0;
        if (nx >= 0) mlast = nx;
        owner = nx;
      end
      gprev = gnt;
    end
  end

  task automatic master_cycle(input int id, input int nb, input int mode);
    int idx, to;
    cyc_d[id] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      idx = (mode == 1) ? (b % 8) : int'($urandom_range(0, 7));
      adr_d[id] = 32'h100 + 32'(idx * 4);
      we_d[id]  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      dat_d[id] = $urandom;
      sel_d[id] = (mode == 1) ? 4'hF : 4'($urandom_range(1, 15));
      stb_d[id] = 1'b1;
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!mack[id] && to < 2000);
      if (!mack[id]) begin
        chk($sformatf("ack_timeout%0d", id), 32'd0, 32'd1);
        stb_d[id] = 1'b0;
        cyc_d[id] = 1'b0;
        return;
      end
      if (!we_d[id]) chk($sformatf("rd_data%0d", id), mdat[id], ref_mem[idx]);
      else
        for (int k = 0; k < 4; k++)
          if (sel_d[id][k]) ref_mem[idx][8*k +: 8] = dat_d[id][8*k +: 8];
      done[id]++;
      @(posedge clk);
      #1;
    end
    stb_d[id] = 1'b0;
    we_d[id]  = 1'b0;
    cyc_d[id] = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, b1, d0, d1, t0_done, t1_done, to;
    for (int i = 0; i < 2; i++) begin
      cyc_d[i] = 1'b0; stb_d[i] = 1'b0; we_d[i] = 1'b0;
      adr_d[i] = 32'h100; dat_d[i] = '0; sel_d[i] = 4'hF;
      ack_by[i] = 0; done[i] = 0;
    end
    rmode = 0; ready = 1'b1; rst_n = 1'b0;

    // Reset held with both masters requesting.
    cyc_d[0] = 1'b1; cyc_d[1] = 1'b1; stb_d[0] = 1'b1; stb_d[1] = 1'b1;
    step(3);
    chk("reset_gnt", {30'd0, gnt}, 32'd0);
    chk("reset_fwd_cyc", {31'd0, s.cyc}, 32'd0);
    #2 rst_n = 1'b1;
    step(1);
    chk("release_gnt", {30'd0, gnt}, 32'd1);
    cyc_d[0] = 1'b0; cyc_d[1] = 1'b0; stb_d[0] = 1'b0; stb_d[1] = 1'b0;
    step(2);

    // Single master: eight writes from master 1.
    b0 = ack_by[0]; b1 = ack_by[1];
    master_cycle(1, 8, 1);
    chk("single_m1_acks", 32'(ack_by[1] - b1), 32'd8);
    chk("single_m0_acks", 32'(ack_by[0] - b0), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("single_mem%0d", i), smem[i], ref_mem[i]);
    step(2);

    // Tie from idle followed by alternation.
    gseq.delete(); idle_wait = 0;
    fork
      begin master_cycle(0, 4, 0); step(1); master_cycle(0, 4, 0); end
      begin master_cycle(1, 4, 0); step(1); master_cycle(1, 4, 0); end
    join
    chk("tie_len", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk($sformatf("tie_seq%0d", i), 32'(gseq[i]), 32'(i % 2));
    chk("tie_idle_cycles", 32'(idle_wait), 32'd1);
    step(2);

    // Stall integrity: master 1 arrives during a long read of master 0.
    gseq.delete(); b0 = ack_by[0];
    fork
      begin master_cycle(0, 20, 2); t0_done = cycles; end
      begin
        to = 0;
        while (ack_by[0] < b0 + 3 && to < 200) begin step(1); to++; end
        master_cycle(1, 1, 2);
        t1_done = cycles;
      end
    join
`ifdef WSHB_ARB_QUANTUM_EN
    chk("stall_order", {31'd0, t1_done < t0_done}, 32'd1);
    chk("stall_len", 32'(gseq.size()), 32'd3);
`else
    chk("stall_order", {31'd0, t1_done > t0_done}, 32'd1);
    chk("stall_len", 32'(gseq.size()), 32'd2);
`endif
    step(2);

    // Master 0 streams ten reads while master 1 waits.
    gseq.delete(); first_acks = 0;
    fork
      master_cycle(0, 10, 2);
      begin step(1); master_cycle(1, 1, 2); end
    join
`ifdef WSHB_ARB_QUANTUM_EN
    chk("quantum_first_acks", 32'(first_acks), 32'(QN));
    chk("quantum_len", 32'(gseq.size()), 32'd3);
    if (gseq.size() == 3) chk("quantum_back", 32'(gseq[2]), 32'd0);
`else
    chk("quantum_first_acks", 32'(first_acks), 32'd10);
    chk("quantum_len", 32'(gseq.size()), 32'd2);
`endif
    step(2);

    // Reset while master 1 waits for an ack.
    rmode = 2;
    step(1);
    cyc_d[1] = 1'b1; stb_d[1] = 1'b1; we_d[1] = 1'b1; adr_d[1] = 32'h104;
    to = 0;
    while (gnt != 2'b10 && to < 10) begin step(1); to++; end
    chk("midrst_gnt_before", {30'd0, gnt}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cyc_stb", {30'd0, s.cyc, s.stb}, 32'd0);
    chk("midrst_gnt", {30'd0, gnt}, 32'd0);
    step(1);
    chk("midrst_gnt_edge", {30'd0, gnt}, 32'd0);
    cyc_d[1] = 1'b0; stb_d[1] = 1'b0; we_d[1] = 1'b0;
    #2 rst_n = 1'b1;
    rmode = 0;
    step(2);

    // Random contention with a random-latency slave.
    rmode = 1;
    b0 = ack_by[0]; b1 = ack_by[1]; d0 = done[0]; d1 = done[1];
    fork
      for (int i = 0; i < 30; i++) begin
        master_cycle(0, int'($urandom_range(1, 6)), 0);
        step(1 + int'($urandom_range(0, 3)));
      end
      for (int j = 0; j < 30; j++) begin
        master_cycle(1, int'($urandom_range(1, 6)), 0);
        step(1 + int'($urandom_range(0, 3)));
      end
    join
    chk("rand_acks0", 32'(ack_by[0] - b0), 32'(done[0] - d0));
    chk("rand_acks1", 32'(ack_by[1] - b1), 32'(done[1] - d1));
    step(3);
    for (int i = 0; i < 8; i++) chk($sformatf("final_mem%0d", i), smem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
